// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with synchronous flush, same-cycle push/pop and an
// occupancy count. Used both for fetched instructions and for the pc tags
// of requests still waiting on memory.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign do_pop      = pop_i && !empty && !flush_i;
  assign do_push     = push_i && (!full || do_pop) && !flush_i;
  assign head_data_o = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o     = count_q;

  // Next pointer/count values; a flush empties the queue and wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only ever read while the slot is occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // A push into a full queue is only legal alongside a pop.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && full && !pop_i));

  // Popping an empty queue means the caller lost track of occupancy.
  a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && !flush_i && empty));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the pc, issues credit-limited word requests,
// tags them with their pc, buffers responses in order and hands them to
// decode. Redirects flush everything and drain stale in-flight responses.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               started_q, started_d;

  logic               req_fire;
  logic               rsp_keep;
  logic [CNT_W:0]     in_use;
  logic               credit_ok;

  fetch_entry_t       entry_push;
  fetch_entry_t       entry_head;
  logic [CNT_W-1:0]   entry_count;
  logic [31:0]        tag_head;
  logic [CNT_W-1:0]   tag_count;

  assign req_fire   = imem_req_valid && imem_req_ready;
  assign rsp_keep   = imem_rsp_valid && (state_q == RUN) && !redirect_valid;
  assign in_use     = (CNT_W + 1)'(outstanding_q) + (CNT_W + 1)'(entry_count);
  assign credit_ok  = (in_use < (CNT_W + 1)'(DEPTH));
  assign entry_push = '{pc: tag_head, inst: imem_rsp_data};

  assign inst_valid = (entry_count != '0);
  assign inst_data  = entry_head.inst;
  assign inst_pc    = entry_head.pc;

  // pc of every accepted request, popped as its response comes back.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_tag_q (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (req_fire && !redirect_valid),
    .push_data_i (imem_req_addr),
    .pop_i       (rsp_keep),
    .head_data_o (tag_head),
    .count_o     (tag_count)
  );

  // Instruction buffer presented to decode; head is the oldest instruction.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_inst_q (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (rsp_keep),
    .push_data_i (entry_push),
    .pop_i       (inst_valid && inst_ready && !redirect_valid),
    .head_data_o (entry_head),
    .count_o     (entry_count)
  );

  // Next-state and request logic: credit-limited fetch in RUN, silent drain after a redirect.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_cnt_d     = drop_cnt_q;
    started_d      = 1'b1;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_q;
    outstanding_d  = outstanding_q - CNT_W'(imem_rsp_valid) + CNT_W'(req_fire);

    if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end

    case (state_q)
      RUN: begin
        imem_req_valid = started_q && credit_ok;
        if (redirect_valid) begin
          pc_d       = word_align(redirect_pc);
          drop_cnt_d = outstanding_d;
          state_d    = (outstanding_d == '0) ? RUN : DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_d = word_align(redirect_pc);
        end
        if (imem_rsp_valid) begin
          drop_cnt_d = drop_cnt_q - CNT_W'(1);
          if (drop_cnt_q == CNT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers; started_q holds requests off for the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      started_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      started_q     <= started_d;
    end
  end

  // While fetching normally every outstanding request has exactly one pc tag.
  a_tags_match : assert property (@(posedge clk) disable iff (rst)
    (state_q != RUN) || (tag_count == outstanding_q));

endmodule
